pipe_stall_ctrl: RTL
====================

# pipe_stall_ctrl

Central hazard and stall controller for the 5-stage pipeline.
- Produces the per-register hold and flush controls consumed by the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers.
- Detects load-use hazards and taken branches, and freezes the pipeline while a multi-cycle data-memory access is outstanding.
- Traps a hung memory access with a timeout error state.

## Interface
Parameters:
- TIMEOUT, default 255: max consecutive cycles with dmem_req_i=1 and dmem_ack_i=0 before the error state is entered (range 1..255).
- CNT_W, default 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- idex_memread_i  in  1  instruction in ID/EX is a load
- idex_rt_i  in  5  load destination register in ID/EX
- ifid_rs_i  in  5  rs of the instruction in IF/ID
- ifid_rt_i  in  5  rt of the instruction in IF/ID
- branch_taken_i  in  1  branch resolved taken in ID this cycle
- dmem_req_i  in  1  EX/MEM instruction is accessing data memory
- dmem_ack_i  in  1  data memory completes the access this cycle
- pc_hold_o, ifid_hold_o, idex_hold_o, exmem_hold_o, memwb_hold_o  out  1 each  register keeps its value
- ifid_flush_o, idex_flush_o, memwb_flush_o  out  1 each  register loads all-zero (bubble)
- err_o  out  1  registered, sticky memory-timeout flag
- stall_cnt_o  out  32  stalled-cycle count (see Configuration)

## Operation
- FSM states: RUN, WAIT, ERR. Reset state is RUN, wait counter 0, err_o=0, stall_cnt_o=0.
- Hold/flush outputs are combinational from the current state and inputs. Only err_o and stall_cnt_o are registered.
- Hold and flush are never asserted together on the same register. All controls not listed for a case are 0.

Priority within RUN (highest first):
1. Memory stall: dmem_req_i=1 and dmem_ack_i=0.
   - Assert pc, ifid, idex and exmem hold, plus memwb_flush.
   - Next state WAIT, counter=1.
2. Load-use: idex_memread_i=1, idex_rt_i≠0, and idex_rt_i equals ifid_rs_i or ifid_rt_i.
   - Assert pc_hold, ifid_hold and idex_flush.
   - branch_taken_i is ignored; the branch re-resolves next cycle.
3. Branch: branch_taken_i=1.
   - Assert ifid_flush only; PC loads the target.
4. Otherwise all controls are 0.

WAIT:
- dmem_ack_i=0:
  - Assert the same controls as a memory stall.
  - Counter increments.
  - If the counter equals TIMEOUT, next state is ERR and err_o is set on that edge.
- dmem_ack_i=1:
  - Evaluate the RUN priority rules this cycle; the memory rule cannot fire.
  - Next state RUN, counter cleared.
- Load-use and branch inputs are ignored while the memory stall rule applies.

ERR:
- All five holds asserted, all flushes 0, err_o=1.
- Exit only via reset.

Other rules:
- Acknowledge in the same cycle as the request (dmem_req_i=dmem_ack_i=1 in RUN): no stall.
- Reset asserted mid-WAIT or in ERR immediately forces RUN, counter 0 and err_o=0. All outputs read 0 while rst_i=0.

## Timing
- Hold/flush: zero-cycle latency, valid in the same cycle as the causing inputs, sampled by the pipe registers on the next rising edge.
- Load-use stall lasts exactly 1 cycle. The bubble in ID/EX clears idex_memread_i, so the hazard drops naturally.
- Memory stall: N cycles of holds for an access acked on the Nth cycle after the request (N ≤ TIMEOUT).
- err_o rises on the edge that ends the TIMEOUT-th consecutive un-acked cycle.
- stall_cnt_o updates one edge after a stalled cycle.

## Configuration
- STALL_CNT_EN defined:
  - stall_cnt_o is a 32-bit counter that increments on every cycle in which pc_hold_o=1, in any state.
  - Saturates at 0xFFFFFFFF. Cleared only by reset.
- STALL_CNT_EN undefined:
  - No counter logic.
  - stall_cnt_o is tied to 0.

## Test plan
- Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 for one cycle → pc_hold_o=ifid_hold_o=idex_flush_o=1 that cycle only; with idex_rt_i=0 → no stall.
- Branch: branch_taken_i=1 alone → ifid_flush_o=1, pc_hold_o=0. Same cycle with a load-use hazard → load-use controls only, ifid_flush_o=0.
- Memory wait: dmem_req_i=1, ack after 3 cycles → holds plus memwb_flush_o for 3 cycles, 0 in the ack cycle, state RUN. With STALL_CNT_EN defined, stall_cnt_o=3.
- Timeout: TIMEOUT=4, req held with no ack → err_o=1 after the 4th cycle, all holds stay 1 for 20 more cycles.
- Reset mid-operation: drop rst_i during WAIT and during ERR → err_o=0 and all controls 0 immediately; normal load-use detection on the first cycle after release.
- Same-cycle ack: dmem_req_i=dmem_ack_i=1 → no hold asserted, state stays RUN.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use, taken-branch and data-memory wait handling.
// Optional stalled-cycle counter is built only when STALL_CNT_EN is defined.
module pipe_stall_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  input  logic       branch_taken_i,
  input  logic       dmem_req_i,
  input  logic       dmem_ack_i,
  output logic       pc_hold_o,
  output logic       ifid_hold_o,
  output logic       idex_hold_o,
  output logic       exmem_hold_o,
  output logic       memwb_hold_o,
  output logic       ifid_flush_o,
  output logic       idex_flush_o,
  output logic       memwb_flush_o,
  output logic       err_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             err_q, err_d;

  logic pc_hold_c, ifid_hold_c, idex_hold_c, exmem_hold_c, memwb_hold_c;
  logic ifid_flush_c, idex_flush_c, memwb_flush_c;
  logic lu_hit;

  function automatic logic load_use_hit(input logic       memread,
                                        input logic [4:0] ld_rt,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt);
    return memread && (ld_rt != 5'd0) && ((ld_rt == rs) || (ld_rt == rt));
  endfunction

  assign lu_hit  = load_use_hit(idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i);
  assign cnt_inc = cnt_q + ONE_C;

  always_comb begin
    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    idex_hold_c   = 1'b0;
    exmem_hold_c  = 1'b0;
    memwb_hold_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    memwb_flush_c = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;

    unique case (state_q)
      RUN: begin
        if (dmem_req_i && !dmem_ack_i) begin
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          idex_hold_c   = 1'b1;
          exmem_hold_c  = 1'b1;
          memwb_flush_c = 1'b1;
          cnt_d         = ONE_C;
          if (ONE_C == TIMEOUT_C) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else if (lu_hit) begin
          pc_hold_c    = 1'b1;
          ifid_hold_c  = 1'b1;
          idex_flush_c = 1'b1;
        end else if (branch_taken_i) begin
          ifid_flush_c = 1'b1;
        end
      end

      WAIT: begin
        if (!dmem_ack_i) begin
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          idex_hold_c   = 1'b1;
          exmem_hold_c  = 1'b1;
          memwb_flush_c = 1'b1;
          cnt_d         = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end else begin
          // Access completes this cycle, so only the lower-priority hazards remain.
          if (lu_hit) begin
            pc_hold_c    = 1'b1;
            ifid_hold_c  = 1'b1;
            idex_flush_c = 1'b1;
          end else if (branch_taken_i) begin
            ifid_flush_c = 1'b1;
          end
          state_d = RUN;
          cnt_d   = '0;
        end
      end

      ERR: begin
        pc_hold_c    = 1'b1;
        ifid_hold_c  = 1'b1;
        idex_hold_c  = 1'b1;
        exmem_hold_c = 1'b1;
        memwb_hold_c = 1'b1;
        err_d        = 1'b1;
      end

      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Reset forces every control low at once, independent of the inputs.
  assign pc_hold_o     = pc_hold_c     & rst_i;
  assign ifid_hold_o   = ifid_hold_c   & rst_i;
  assign idex_hold_o   = idex_hold_c   & rst_i;
  assign exmem_hold_o  = exmem_hold_c  & rst_i;
  assign memwb_hold_o  = memwb_hold_c  & rst_i;
  assign ifid_flush_o  = ifid_flush_c  & rst_i;
  assign idex_flush_o  = idex_flush_c  & rst_i;
  assign memwb_flush_o = memwb_flush_c & rst_i;
  assign err_o         = err_q;

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (pc_hold_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
